// File: rtl/mult_pkg.sv
// Shared definitions for the shared-multiplier arbiter: tag sizing and the
// record carried by each multiply pipeline stage.
package mult_pkg;

    localparam int TAG_W_MAX  = 8;
    localparam int PROD_W_MAX = 64;

    function automatic int tag_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Fields are sized for the largest supported configuration; users slice down.
    typedef struct packed {
        logic                  valid;
        logic [TAG_W_MAX-1:0]  tag;
        logic [PROD_W_MAX-1:0] product;
    } pipe_stage_t;

endpackage

// File: rtl/mult_pipe.sv
// Partial-product multiplier followed by LATENCY register stages that carry
// the valid bit and requester tag alongside the product.
module mult_pipe
    import mult_pkg::*;
#(
    parameter int WIDTH_A = 4,
    parameter int WIDTH_B = 4,
    parameter int TAG_W   = 2,
    parameter int LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [WIDTH_A-1:0]         in_a,
    input  logic [WIDTH_B-1:0]         in_b,
    output logic                       out_valid,
    output logic [TAG_W-1:0]           out_tag,
    output logic [WIDTH_A+WIDTH_B-1:0] out_p
);

    localparam int PW = WIDTH_A + WIDTH_B;

    logic [PW-1:0] prod;
    pipe_stage_t   stage_q [LATENCY];
    pipe_stage_t   stage_d [LATENCY];

    always_comb begin
        prod = '0;
        for (int j = 0; j < WIDTH_B; j++) begin
            prod = prod + (PW'(in_a & {WIDTH_A{in_b[j]}}) << j);
        end
    end

    // The product field only loads on a valid entry, so idle cycles keep
    // presenting the last real product at the output.
    always_comb begin
        stage_d[0].valid   = in_valid;
        stage_d[0].tag     = TAG_W_MAX'(in_tag);
        stage_d[0].product = in_valid ? PROD_W_MAX'(prod) : stage_q[0].product;
        for (int s = 1; s < LATENCY; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < LATENCY; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign out_valid = stage_q[LATENCY-1].valid;
    assign out_tag   = stage_q[LATENCY-1].tag[TAG_W-1:0];
    assign out_p     = stage_q[LATENCY-1].product[PW-1:0];

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NUM_REQ requesters.
// Define MULT_SHARE_PERF_EN to add the busy_cnt transfer counter port.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int WIDTH_A = 4,
    parameter int WIDTH_B = 4,
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH_A-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH_B-1:0]   req_b,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [WIDTH_A+WIDTH_B-1:0]   rsp_p
`ifdef MULT_SHARE_PERF_EN
    ,
    output logic [31:0]                  busy_cnt
`endif
);

    localparam int TAG_W = tag_width(NUM_REQ);

    logic [TAG_W-1:0]   ptr_q, ptr_d;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W-1:0]   idx;
    logic               grant_any;
    logic [WIDTH_A-1:0] sel_a;
    logic [WIDTH_B-1:0] sel_b;
    logic               pipe_valid;
    logic [TAG_W-1:0]   pipe_tag;

    // First valid requester at or after ptr, wrapping past NUM_REQ-1.
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = TAG_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (TAG_W'(k) == grant_idx) begin
                sel_a = req_a[k*WIDTH_A +: WIDTH_A];
                sel_b = req_b[k*WIDTH_B +: WIDTH_B];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    mult_pipe #(
        .WIDTH_A (WIDTH_A),
        .WIDTH_B (WIDTH_B),
        .TAG_W   (TAG_W),
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (grant_any),
        .in_tag    (grant_idx),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag),
        .out_p     (rsp_p)
    );

    always_comb begin
        rsp_valid = '0;
        if (pipe_valid) begin
            rsp_valid[pipe_tag] = 1'b1;
        end
    end

`ifdef MULT_SHARE_PERF_EN
    logic [31:0] busy_cnt_q, busy_cnt_d;

    always_comb begin
        busy_cnt_d = busy_cnt_q + 32'(grant_any);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt_q <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized and directed bench for mult_share_arbiter against a queue-based
// reference model of round-robin grants and tagged in-order responses.
module tb_mult_share_arbiter;

    localparam int WA  = 4;
    localparam int WB  = 4;
    localparam int N   = 4;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*WA-1:0]   req_a = '0;
    logic [N*WB-1:0]   req_b = '0;
    logic [N-1:0]      rsp_valid;
    logic [WA+WB-1:0]  rsp_p;
`ifdef MULT_SHARE_PERF_EN
    logic [31:0]       busy_cnt;
`endif

    always #5 clk = ~clk;

    mult_share_arbiter #(
        .WIDTH_A (WA),
        .WIDTH_B (WB),
        .NUM_REQ (N),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p)
`ifdef MULT_SHARE_PERF_EN
        ,
        .busy_cnt  (busy_cnt)
`endif
    );

    typedef struct {
        int cyc;
        int tag;
        int prod;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   mptr     = 0;
    int   n_xfer   = 0;
    bit   rst_next = 1'b1;
    bit   pend [N];
    int   pa   [N];
    int   pb   [N];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, then advance it.
    task automatic step();
        int           g;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        rst = rst_next;
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = pend[i];
            req_a[i*WA +: WA]   = WA'(pa[i]);
            req_b[i*WB +: WB]   = WB'(pb[i]);
        end
        if (rst) begin
            exp_q.delete();
            mptr   = 0;
            n_xfer = 0;
        end
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
`ifdef MULT_SHARE_PERF_EN
        check_eq("busy_cnt", 64'(busy_cnt), 64'(n_xfer));
`endif
        if (rst) begin
            check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check_eq("rst_rsp_p", 64'(rsp_p), 64'd0);
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            check_eq("rsp_valid", 64'(rsp_valid), 64'(1) << exp_q[0].tag);
            check_eq("rsp_p", 64'(rsp_p), 64'(exp_q[0].prod));
            void'(exp_q.pop_front());
        end else begin
            check_eq("rsp_idle", 64'(rsp_valid), 64'd0);
        end
        if (!rst && g >= 0) begin
            exp_q.push_back('{cyc: cyc + LAT, tag: g, prod: pa[g] * pb[g]});
            pend[g] = 1'b0;
            mptr    = (g + 1) % N;
            n_xfer++;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_req(input int i, input int a, input int b);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pa[i]   = 0;
            pb[i]   = 0;
        end
        rst_next = 1'b1;
        idle(2);
        rst_next = 1'b0;
        idle(1);

        // Single requester, maximum operands.
        set_req(0, 15, 15);
        idle(LAT + 2);

        // Full contention with continuously re-armed requesters.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) if (!pend[i]) set_req(i, i + 1, 2);
            step();
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        idle(LAT + 1);

        // Back-to-back from one index, including a zero operand.
        set_req(2, 3, 5);
        step();
        set_req(2, 0, 9);
        step();
        idle(LAT + 1);

        // Pointer sits at 3 here: grant 3, then wrap to 1.
        set_req(1, 7, 6);
        set_req(3, 9, 11);
        idle(LAT + 3);

        // Reset with a multiply in flight.
        set_req(0, 13, 12);
        step();
        rst_next = 1'b1;
        step();
        rst_next = 1'b0;
        set_req(2, 5, 5);
        set_req(3, 6, 6);
        idle(LAT + 4);

        // Randomized traffic with occasional withdrawals.
        for (int c = 0; c < 600; c++) begin
            int load;
            load = (c / 150) % 4;
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(3, 0) < load + 1) begin
                        set_req(i, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            if ($urandom_range(99, 0) == 0) rst_next = 1'b1;
            else rst_next = 1'b0;
            step();
        end
        rst_next = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        idle(LAT + 2);

        // Reset clears the counter (checked when the perf port exists).
        rst_next = 1'b1;
        step();
        rst_next = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
